// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

    localparam int REG_ADDR_W_DEF = 5;
    localparam logic [REG_ADDR_W_DEF-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REFILL   = 2'd2
    } ctrl_state_e;

    // One enable/clear pair per pipeline register, plus the PC write enable.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_clr;
        logic idex_en;
        logic idex_clr;
        logic exmem_en;
        logic exmem_clr;
        logic memwb_en;
        logic memwb_clr;
    } ctl_t;

    localparam ctl_t CTL_NORMAL = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam ctl_t CTL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam ctl_t CTL_LU     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam ctl_t CTL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

endpackage

// File: rtl/hazard_load_use_detect.sv
// Flags an ID instruction that reads the destination of a load currently in EX.
module hazard_load_use_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    output logic                  load_use
);

    // x0 never carries a real dependency.
    assign load_use = ex_mem_read && (ex_rd != REG_ADDR_W'(REG_ZERO)) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline registers and PC.
// Optional HAZARD_PERF_EN adds saturating stall-cycle and flush-event counters.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W    = REG_ADDR_W_DEF,
    parameter int REFILL_CYCLES = 1,
    parameter int CNT_W         = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_redirect,
    input  logic                  mem_stall,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  ifid_clr,
    output logic                  idex_en,
    output logic                  idex_clr,
    output logic                  exmem_en,
    output logic                  exmem_clr,
    output logic                  memwb_en,
    output logic                  memwb_clr,
`ifdef HAZARD_PERF_EN
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_flush_events,
`endif
    output logic [1:0]            ctrl_state
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFILL_CYCLES);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             load_use;
    logic             is_flush;
    ctl_t             ctl, ctl_o;

    hazard_load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lu (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        ctl      = CTL_NORMAL;
        is_flush = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    ctl     = CTL_FREEZE;
                    pend_d  = ex_redirect;
                    state_d = MEM_WAIT;
                end else if (ex_redirect) begin
                    ctl      = CTL_FLUSH;
                    is_flush = 1'b1;
                    if (REFILL_CYCLES > 0) begin
                        cnt_d   = RELOAD;
                        state_d = REFILL;
                    end
                end else if (load_use) begin
                    ctl = CTL_LU;
                end
            end
            MEM_WAIT: begin
                if (mem_stall) begin
                    ctl    = CTL_FREEZE;
                    pend_d = pend_q | ex_redirect;
                end else if (pend_q || ex_redirect) begin
                    // A redirect seen at any point during the wait is applied on release.
                    ctl      = CTL_FLUSH;
                    is_flush = 1'b1;
                    pend_d   = 1'b0;
                    cnt_d    = RELOAD;
                    state_d  = (REFILL_CYCLES > 0) ? REFILL : RUN;
                end else if (cnt_q != '0) begin
                    ctl.ifid_clr = 1'b1;
                    cnt_d        = cnt_q - 1'b1;
                    state_d      = (cnt_q == CNT_W'(1)) ? RUN : REFILL;
                end else begin
                    if (load_use) ctl = CTL_LU;
                    state_d = RUN;
                end
            end
            REFILL: begin
                if (mem_stall) begin
                    ctl     = CTL_FREEZE;
                    pend_d  = ex_redirect;
                    state_d = MEM_WAIT;
                end else if (ex_redirect) begin
                    ctl      = CTL_FLUSH;
                    is_flush = 1'b1;
                    cnt_d    = RELOAD;
                end else begin
                    ctl.ifid_clr = 1'b1;
                    cnt_d        = cnt_q - 1'b1;
                    if (cnt_q <= CNT_W'(1)) state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
                pend_d  = 1'b0;
            end
        endcase
    end

    assign ctl_o      = reset ? '0 : ctl;
    assign pc_en      = ctl_o.pc_en;
    assign ifid_en    = ctl_o.ifid_en;
    assign ifid_clr   = ctl_o.ifid_clr;
    assign idex_en    = ctl_o.idex_en;
    assign idex_clr   = ctl_o.idex_clr;
    assign exmem_en   = ctl_o.exmem_en;
    assign exmem_clr  = ctl_o.exmem_clr;
    assign memwb_en   = ctl_o.memwb_en;
    assign memwb_clr  = ctl_o.memwb_clr;
    assign ctrl_state = reset ? 2'd0 : state_q;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_flush_events <= '0;
        end else begin
            if (!ctl.pc_en && (perf_stall_cycles != '1))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (is_flush && (perf_flush_events != '1))
                perf_flush_events <= perf_flush_events + 32'd1;
        end
    end
`endif

endmodule
